sample_packer: RTL and testbench

Downstream consumer of the correlator's programmable clock divider. On each divider overflow strobe it captures one 1-bit sample per antenna channel and packs WORD_BITS consecutive samples per channel into a word. Words queue in a small show-ahead FIFO and leave through a valid/ready handshake towards the correlation core. Words that arrive while the FIFO is full are dropped and counted.

---
 rtl/sample_packer.sv | 150 +++++++++++++++
 tb/tb_sample_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_packer.sv
// sample_packer: packs WORD_BITS ticked 1-bit samples per channel into words queued in a show-ahead FIFO.
// Optional feature macro: SAMPLE_PACKER_TIMESTAMP_EN adds a per-word tick timestamp (out_timestamp).
module sample_packer #(
    parameter int CHANNELS   = 2,
    parameter int WORD_BITS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic                                tick,
    input  logic [CHANNELS-1:0]                 sample_in,
    output logic [CHANNELS*WORD_BITS-1:0]       out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(FIFO_DEPTH):0]         fill,
    output logic [15:0]                         dropped
`ifdef SAMPLE_PACKER_TIMESTAMP_EN
    ,
    output logic [31:0]                         out_timestamp
`endif
);

    localparam int DW = CHANNELS * WORD_BITS;
    localparam int CW = $clog2(WORD_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [CW-1:0] bit_cnt_r;
    logic [DW-1:0] shift_r;
    logic [DW-1:0] next_shift_s;
    logic [DW-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   fill_r;
    logic [15:0]   dropped_r;
    logic          capture_s;
    logic          complete_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    assign capture_s  = enable && tick;
    assign complete_s = capture_s && (bit_cnt_r == CW'(WORD_BITS - 1));
    assign full_s     = (fill_r == (PW + 1)'(FIFO_DEPTH));
    assign pop_s      = (fill_r != '0) && out_ready;
    assign push_s     = complete_s && (!full_s || pop_s);
    assign drop_s     = complete_s && !push_s;

    assign out_data  = mem_r[rd_ptr_r];
    assign out_valid = (fill_r != '0);
    assign fill      = fill_r;
    assign dropped   = dropped_r;

    // Shift image with the current sample written at bit_cnt (completed word when bit_cnt is last)
    always_comb begin
        next_shift_s = shift_r;
        for (int c = 0; c < CHANNELS; c++) begin
            next_shift_s[c*WORD_BITS + int'(bit_cnt_r)] = sample_in[c];
        end
    end

    // Bit counter and per-channel shift registers; disabling abandons the partial word
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
        end else if (!enable) begin
            bit_cnt_r <= '0;
        end else if (tick) begin
            shift_r <= next_shift_s;
            if (complete_s) begin
                bit_cnt_r <= '0;
            end else begin
                bit_cnt_r <= bit_cnt_r + CW'(1);
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Show-ahead FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= next_shift_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fill_r <= fill_r + (PW + 1)'(1);
                2'b01:   fill_r <= fill_r - (PW + 1)'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Saturating count of words lost to a full FIFO
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dropped_r <= 16'h0000;
        end else if (drop_s && (dropped_r != 16'hFFFF)) begin
            dropped_r <= dropped_r + 16'h0001;
        end else begin
            dropped_r <= dropped_r;
        end
    end

`ifdef SAMPLE_PACKER_TIMESTAMP_EN
    logic [31:0] tick_cnt_r;
    logic [31:0] ts_start_r;
    logic [31:0] ts_mem_r [FIFO_DEPTH];
    logic [31:0] word_ts_s;

    // A word's stamp is the counter value at its bit-0 sample
    assign word_ts_s     = (bit_cnt_r == '0) ? tick_cnt_r : ts_start_r;
    assign out_timestamp = ts_mem_r[rd_ptr_r];

    // Free-running accepted-tick counter and per-entry timestamp storage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_r <= 32'h0000_0000;
            ts_start_r <= 32'h0000_0000;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ts_mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (capture_s) begin
                tick_cnt_r <= tick_cnt_r + 32'h0000_0001;
                ts_start_r <= word_ts_s;
            end
            if (push_s) begin
                ts_mem_r[wr_ptr_r] <= word_ts_s;
            end
        end
    end
`else
    // Timestamp counter and storage are not built in this configuration.
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: directed scenarios plus random traffic against a queue-based model.
module tb_sample_packer;

    localparam int CHANNELS   = 2;
    localparam int WORD_BITS  = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int DW         = CHANNELS * WORD_BITS;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic                          enable;
    logic                          tick;
    logic [CHANNELS-1:0]           sample_in;
    logic [DW-1:0]                 out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [$clog2(FIFO_DEPTH):0]   fill;
    logic [15:0]                   dropped;
`ifdef SAMPLE_PACKER_TIMESTAMP_EN
    logic [31:0]                   out_timestamp;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0]       m_q[$];
    int unsigned         m_ts[$];
    logic [CHANNELS-1:0] m_part[$];
    int unsigned         m_dropped = 0;
    int unsigned         m_ticks = 0;
    int unsigned         m_start = 0;

    sample_packer #(
        .CHANNELS(CHANNELS), .WORD_BITS(WORD_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .tick(tick),
        .sample_in(sample_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fill(fill), .dropped(dropped)
`ifdef SAMPLE_PACKER_TIMESTAMP_EN
        , .out_timestamp(out_timestamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs that were applied to the DUT
    task automatic model_step();
        bit do_pop;
        bit full;
        bit done;
        logic [DW-1:0] w;
        if (!reset_n) begin
            m_q.delete(); m_ts.delete(); m_part.delete();
            m_dropped = 0; m_ticks = 0;
            return;
        end
        do_pop = (m_q.size() != 0) && out_ready;
        full   = (m_q.size() == FIFO_DEPTH);
        done   = 1'b0;
        w      = '0;
        if (!enable) begin
            m_part.delete();
        end else if (tick) begin
            if (m_part.size() == 0) m_start = m_ticks;
            m_part.push_back(sample_in);
            m_ticks++;
            if (m_part.size() == WORD_BITS) begin
                for (int i = 0; i < WORD_BITS; i++)
                    for (int c = 0; c < CHANNELS; c++)
                        w[c*WORD_BITS + i] = m_part[i][c];
                done = 1'b1;
                m_part.delete();
            end
        end
        if (do_pop) begin
            void'(m_q.pop_front());
            void'(m_ts.pop_front());
        end
        if (done) begin
            if (!full || do_pop) begin
                m_q.push_back(w);
                m_ts.push_back(m_start);
            end else if (m_dropped != 32'h0000FFFF) begin
                m_dropped++;
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", DW'(out_valid), DW'(m_q.size() != 0));
        chk("fill", DW'(fill), DW'(m_q.size()));
        chk("dropped", DW'(dropped), DW'(m_dropped));
        if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0]);
`ifdef SAMPLE_PACKER_TIMESTAMP_EN
            chk("out_timestamp", DW'(out_timestamp), DW'(m_ts[0]));
`endif
        end
    endtask

    task automatic cycle(input logic rst, input logic en, input logic tk,
                         input logic [CHANNELS-1:0] smp, input logic rdy);
        reset_n = rst; enable = en; tick = tk; sample_in = smp; out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int guard;
        reset_n = 1'b0; enable = 1'b0; tick = 1'b0; sample_in = '0; out_ready = 1'b0;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("reset_out_data", out_data, '0);
        chk("reset_out_valid", DW'(out_valid), DW'(0));
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);

        // Basic packing: ch0 alternating starting at 1, ch1 constant 1
        for (int i = 0; i < WORD_BITS; i++) begin
            cycle(1'b1, 1'b1, 1'b1, {1'b1, (i % 2 == 0) ? 1'b1 : 1'b0}, 1'b1);
        end
        chk("basic_valid", DW'(out_valid), DW'(1));
        chk("basic_word", out_data, {32'hFFFF_FFFF, 32'h5555_5555});
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        chk("basic_fill_after", DW'(fill), DW'(0));

        // Backpressure: six words into a four-entry FIFO
        for (int i = 0; i < 6 * WORD_BITS; i++) begin
            cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b0);
        end
        chk("ovf_fill", DW'(fill), DW'(4));
        chk("ovf_dropped", DW'(dropped), DW'(2));

        // Full FIFO: word completes on the same edge as a pop
        for (int i = 0; i < WORD_BITS - 1; i++) begin
            cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b0);
        end
        cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b1);
        chk("pushpop_fill", DW'(fill), DW'(4));
        chk("pushpop_dropped", DW'(dropped), DW'(2));
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        end
        chk("drained_fill", DW'(fill), DW'(0));

        // Enable abort after 10 ticks, then a full word
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b1);
        cycle(1'b1, 1'b0, 1'b1, CHANNELS'($urandom), 1'b1);
        for (int i = 0; i < WORD_BITS; i++) begin
            chk("abort_no_word_yet", DW'(out_valid), DW'(0));
            cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b1);
        end
        chk("abort_one_word", DW'(fill), DW'(1));
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);

        // Build fill=3, dropped=5, then reset
        guard = 0;
        while (m_dropped < 5 && guard < 2000) begin
            cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b0);
            guard++;
        end
        chk("setup_dropped_bound", DW'(guard < 2000), DW'(1));
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        chk("pre_reset_fill", DW'(fill), DW'(3));
        chk("pre_reset_dropped", DW'(dropped), DW'(5));
        cycle(1'b0, 1'b1, 1'b1, 2'b11, 1'b0);
        chk("post_reset_valid", DW'(out_valid), DW'(0));
        chk("post_reset_fill", DW'(fill), DW'(0));
        chk("post_reset_dropped", DW'(dropped), DW'(0));
        for (int i = 0; i < WORD_BITS - 1; i++) cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b0);
        chk("post_reset_partial", DW'(out_valid), DW'(0));
        cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b0);
        chk("post_reset_word", DW'(out_valid), DW'(1));

        // Two more words behind it, then pop all three
        for (int i = 0; i < 2 * WORD_BITS; i++) cycle(1'b1, 1'b1, 1'b1, CHANNELS'($urandom), 1'b0);
`ifdef SAMPLE_PACKER_TIMESTAMP_EN
        chk("ts_word0", DW'(out_timestamp), DW'(0));
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        chk("ts_word1", DW'(out_timestamp), DW'(32));
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        chk("ts_word2", DW'(out_timestamp), DW'(64));
`endif
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 999) != 0), ($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 3) != 0), CHANNELS'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
